// File: rtl/macpu_rst_sequencer.sv
// macpu_rst_sequencer
//   Controlled reset bring-up for the MACPU system top. The MMCM lock is
//   synchronised, all consumers are held in reset for HOLD_CYCLES after lock,
//   then CHANNELS active-low resets are released in order 0..CHANNELS-1, one
//   every STAGGER_CYCLES. Lock loss or a soft-reset request re-sequences.
//
// Optional feature (compile-time macro): MACPU_RSTSEQ_WDT_EN
//   Builds a lock-wait watchdog that sets o_lock_timeout after WDT_CYCLES
//   consecutive cycles in WAIT_LOCK. When undefined, o_lock_timeout is 0.
//
// Ports
//   clk             sequencer clock (CPU core clock domain)
//   rst             asynchronous active-high reset
//   i_locked        MMCM locked, asynchronous to clk
//   i_soft_rst_req  single-cycle request to re-sequence (honoured in RUN only)
//   o_n_rst         per-channel active-low resets, channel 0 released first
//   o_ready         all channels released
//   o_lock_lost_cnt saturating count of lock-loss events
//   o_lock_timeout  sticky lock-wait timeout flag
module macpu_rst_sequencer #(
  parameter int CHANNELS       = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int WDT_CYCLES     = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_locked,
  input  logic                i_soft_rst_req,
  output logic [CHANNELS-1:0] o_n_rst,
  output logic                o_ready,
  output logic [7:0]          o_lock_lost_cnt,
  output logic                o_lock_timeout
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  state_t                state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  locked_s;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [CH_W-1:0]       ch, ch_nxt;
  logic [CHANNELS-1:0]   n_rst_nxt;
  logic                  ready_nxt;
  logic [7:0]            lost_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    n_rst_nxt = o_n_rst;
    ready_nxt = o_ready;
    lost_nxt  = o_lock_lost_cnt;

    // Lock loss outside WAIT_LOCK wins over everything, including a soft
    // request in the same cycle, and counts as one event.
    if (state != WAIT_LOCK && !locked_s) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
      n_rst_nxt = '0;
      ready_nxt = 1'b0;
      lost_nxt  = sat_inc8(o_lock_lost_cnt);
    end else begin
      case (state)
        WAIT_LOCK: begin
          n_rst_nxt = '0;
          ready_nxt = 1'b0;
          if (locked_s) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            // Channel 0 goes out together with the move to RELEASE.
            state_nxt = RELEASE;
            ch_nxt    = '0;
            cnt_nxt   = '0;
            n_rst_nxt = CHANNELS'(1);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RELEASE: begin
          // ch is the most recently released channel; releases are strictly
          // in order so the next pattern is a left shift with a 1 filled in.
          if (ch == CH_LAST) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else if (cnt == STAGGER_LAST) begin
            ch_nxt    = ch + 1'b1;
            cnt_nxt   = '0;
            n_rst_nxt = (o_n_rst << 1) | CHANNELS'(1);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RUN: begin
          if (i_soft_rst_req) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            n_rst_nxt = '0;
            ready_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = WAIT_LOCK;
          n_rst_nxt = '0;
          ready_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= WAIT_LOCK;
      sync_q          <= '0;
      cnt             <= '0;
      ch              <= '0;
      o_n_rst         <= '0;
      o_ready         <= 1'b0;
      o_lock_lost_cnt <= 8'd0;
    end else begin
      state           <= state_nxt;
      sync_q          <= {sync_q[SYNC_STAGES-2:0], i_locked};
      cnt             <= cnt_nxt;
      ch              <= ch_nxt;
      o_n_rst         <= n_rst_nxt;
      o_ready         <= ready_nxt;
      o_lock_lost_cnt <= lost_nxt;
    end
  end

`ifdef MACPU_RSTSEQ_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

  logic [WDT_W-1:0] wdt_cnt;
  logic             timeout_q;

  // Counts consecutive WAIT_LOCK cycles; holds at its last value once the
  // flag is set so the flag stays sticky until lock arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt   <= '0;
      timeout_q <= 1'b0;
    end else if (state == WAIT_LOCK) begin
      if (locked_s) begin
        wdt_cnt   <= '0;
        timeout_q <= 1'b0;
      end else if (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
        timeout_q <= 1'b1;
      end else begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
    end else begin
      wdt_cnt <= '0;
    end
  end

  assign o_lock_timeout = timeout_q;
`else
  assign o_lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_macpu_rst_sequencer.sv
// Directed bench for macpu_rst_sequencer with default timing parameters and
// WDT_CYCLES = 100. Inputs change on the falling edge; outputs are sampled on
// the falling edge, so step(n) means "n rising edges have occurred".
module tb_macpu_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_locked;
  logic       i_soft_rst_req;
  logic [3:0] o_n_rst;
  logic       o_ready;
  logic [7:0] o_lock_lost_cnt;
  logic       o_lock_timeout;

  int checks   = 0;
  int failures = 0;

  macpu_rst_sequencer #(
    .CHANNELS      (4),
    .HOLD_CYCLES   (16),
    .STAGGER_CYCLES(8),
    .SYNC_STAGES   (2),
    .WDT_CYCLES    (100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_locked       (i_locked),
    .i_soft_rst_req (i_soft_rst_req),
    .o_n_rst        (o_n_rst),
    .o_ready        (o_ready),
    .o_lock_lost_cnt(o_lock_lost_cnt),
    .o_lock_timeout (o_lock_timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

`ifdef MACPU_RSTSEQ_WDT_EN
  localparam logic WDT_ON = 1'b1;
`else
  localparam logic WDT_ON = 1'b0;
`endif

  initial begin
    rst = 1'b1; i_locked = 1'b0; i_soft_rst_req = 1'b0;
    step(3);
    check("rst_n_rst",   32'(o_n_rst), 32'h0);
    check("rst_ready",   32'(o_ready), 32'h0);
    check("rst_cnt",     32'(o_lock_lost_cnt), 32'h0);
    check("rst_timeout", 32'(o_lock_timeout), 32'h0);

    // Lock held low: watchdog (when built) trips after 100 cycles.
    rst = 1'b0;
    step(99);
    check("wdt_99",  32'(o_lock_timeout), 32'h0);
    step(1);
    check("wdt_100", 32'(o_lock_timeout), 32'(WDT_ON));
    check("wait_n_rst", 32'(o_n_rst), 32'h0);

    // First bring-up: lock rises, locked_s after 2 edges, HOLD at edge 3.
    i_locked = 1'b1;
    step(2);
    check("wdt_sticky", 32'(o_lock_timeout), 32'(WDT_ON));
    step(1);
    check("wdt_clear", 32'(o_lock_timeout), 32'h0);
    step(15);
    check("up_e18", 32'(o_n_rst), 32'h0);
    step(1);
    check("up_e19", 32'(o_n_rst), 32'h1);
    step(7);
    check("up_e26", 32'(o_n_rst), 32'h1);
    step(1);
    check("up_e27", 32'(o_n_rst), 32'h3);
    step(7);
    check("up_e34", 32'(o_n_rst), 32'h3);
    step(1);
    check("up_e35", 32'(o_n_rst), 32'h7);
    step(8);
    check("up_e43", 32'(o_n_rst), 32'hF);
    check("up_e43_ready", 32'(o_ready), 32'h0);
    step(1);
    check("up_e44_ready", 32'(o_ready), 32'h1);
    check("up_cnt", 32'(o_lock_lost_cnt), 32'h0);

    // Lock loss in RUN: outputs drop 3 edges after i_locked falls.
    i_locked = 1'b0;
    step(2);
    check("loss_e2", 32'(o_n_rst), 32'hF);
    step(1);
    check("loss_e3",       32'(o_n_rst), 32'h0);
    check("loss_e3_ready", 32'(o_ready), 32'h0);
    check("loss_cnt",      32'(o_lock_lost_cnt), 32'h1);
    step(2);
    i_locked = 1'b1;
    step(18);
    check("relock_e18", 32'(o_n_rst), 32'h0);
    step(1);
    check("relock_e19", 32'(o_n_rst), 32'h1);
    step(24);
    check("relock_e43", 32'(o_n_rst), 32'hF);
    check("relock_e43_ready", 32'(o_ready), 32'h0);
    step(1);
    check("relock_ready", 32'(o_ready), 32'h1);

    // Soft reset in RUN, then ignored pulses in HOLD and RELEASE.
    i_soft_rst_req = 1'b1;
    step(1);
    i_soft_rst_req = 1'b0;
    check("soft_n_rst", 32'(o_n_rst), 32'h0);
    check("soft_ready", 32'(o_ready), 32'h0);
    check("soft_cnt",   32'(o_lock_lost_cnt), 32'h1);
    step(5);
    i_soft_rst_req = 1'b1;
    step(1);
    i_soft_rst_req = 1'b0;
    step(9);
    check("soft_e15", 32'(o_n_rst), 32'h0);
    step(1);
    check("soft_e16", 32'(o_n_rst), 32'h1);
    step(3);
    i_soft_rst_req = 1'b1;
    step(1);
    i_soft_rst_req = 1'b0;
    step(4);
    check("soft_e24", 32'(o_n_rst), 32'h3);
    step(7);
    check("soft_e31", 32'(o_n_rst), 32'h3);
    step(1);
    check("soft_e32", 32'(o_n_rst), 32'h7);
    step(8);
    check("soft_e40", 32'(o_n_rst), 32'hF);
    step(1);
    check("soft_ready_back", 32'(o_ready), 32'h1);

    // Lock loss and soft request in the same cycle: one event, WAIT_LOCK.
    i_locked = 1'b0;
    step(2);
    i_soft_rst_req = 1'b1;
    step(1);
    i_soft_rst_req = 1'b0;
    check("prio_n_rst", 32'(o_n_rst), 32'h0);
    check("prio_cnt",   32'(o_lock_lost_cnt), 32'h2);
    i_soft_rst_req = 1'b1;
    step(1);
    i_soft_rst_req = 1'b0;
    step(4);
    check("wait_soft_n_rst", 32'(o_n_rst), 32'h0);
    check("wait_soft_ready", 32'(o_ready), 32'h0);
    check("wait_soft_cnt",   32'(o_lock_lost_cnt), 32'h2);

    // Each iteration reaches HOLD then loses lock: one event per pass.
    for (int i = 0; i < 253; i++) begin
      i_locked = 1'b1; step(4);
      i_locked = 1'b0; step(4);
    end
    check("sat_255", 32'(o_lock_lost_cnt), 32'hFF);
    for (int i = 0; i < 47; i++) begin
      i_locked = 1'b1; step(4);
      i_locked = 1'b0; step(4);
    end
    check("sat_hold", 32'(o_lock_lost_cnt), 32'hFF);

    // Asynchronous reset mid-sequence.
    i_locked = 1'b1;
    step(30);
    check("pre_arst", 32'(o_n_rst), 32'h3);
    #2 rst = 1'b1;
    #1;
    check("arst_n_rst", 32'(o_n_rst), 32'h0);
    check("arst_cnt",   32'(o_lock_lost_cnt), 32'h0);
    check("arst_ready", 32'(o_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(18);
    check("post_arst_e18", 32'(o_n_rst), 32'h0);
    step(1);
    check("post_arst_e19", 32'(o_n_rst), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
